// File: rtl/writeback_queue_pkg.sv
// ----------------------------------------------------------------------------
// writeback_queue_pkg
// Shared definitions for the write-back result queue.
//   DEPTH_DEF / ADDR_W_DEF / DATA_W_DEF : default queue depth and field widths
//   entry_t                             : one queued result {address, data}
//   cnt_width()                         : width of an occupancy counter that
//                                         must hold the value DEPTH itself
// ----------------------------------------------------------------------------
package writeback_queue_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    // Default-width view of a queued result.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

    // Occupancy runs 0..DEPTH inclusive, so one bit more than the pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// ----------------------------------------------------------------------------
// writeback_queue_if
// Bundles every non-clock signal of the write-back queue.
//   execute side  : iValid, oReady, iResult_Add, iResult_Data
//   regfile side  : oWrite_Enable, iWrite_Ack, oWrite_Add, oWrite_Data
//   forwarding    : Result_Valid, Result_Add, Result_Data
//   decode side   : Source_Add1, Source_Add2, oHazard
//   status        : oCount, oOverflow
// Modports: master = surrounding pipeline, slave = the queue itself.
// ----------------------------------------------------------------------------
interface writeback_queue_if
    import writeback_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) ();
    localparam int CW = cnt_width(DEPTH);

    logic              iValid;
    logic              oReady;
    logic [ADDR_W-1:0] iResult_Add;
    logic [DATA_W-1:0] iResult_Data;

    logic              oWrite_Enable;
    logic              iWrite_Ack;
    logic [ADDR_W-1:0] oWrite_Add;
    logic [DATA_W-1:0] oWrite_Data;

    logic              Result_Valid;
    logic [ADDR_W-1:0] Result_Add;
    logic [DATA_W-1:0] Result_Data;

    logic [ADDR_W-1:0] Source_Add1;
    logic [ADDR_W-1:0] Source_Add2;
    logic              oHazard;

    logic [CW-1:0]     oCount;
    logic              oOverflow;

    modport master (
        output iValid, iResult_Add, iResult_Data, iWrite_Ack, Source_Add1, Source_Add2,
        input  oReady, oWrite_Enable, oWrite_Add, oWrite_Data,
               Result_Valid, Result_Add, Result_Data, oHazard, oCount, oOverflow
    );

    modport slave (
        input  iValid, iResult_Add, iResult_Data, iWrite_Ack, Source_Add1, Source_Add2,
        output oReady, oWrite_Enable, oWrite_Add, oWrite_Data,
               Result_Valid, Result_Add, Result_Data, oHazard, oCount, oOverflow
    );

endinterface

// File: rtl/writeback_queue_fifo.sv
// ----------------------------------------------------------------------------
// writeback_fifo
// Circular result buffer: storage, head/tail pointers, occupancy and flags.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write {addr_i, data_i} at the tail (ignored when full)
//   pop_i        : retire the head entry (ignored when empty)
//   head_addr_o  : address field of the head entry (raw, not masked)
//   head_data_o  : data field of the head entry (raw, not masked)
//   head_ptr_o   : current head index, for age-ordered scans of tag_o
//   tag_o        : address field of every slot, indexed by slot number
//   count_o      : occupancy 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
// ----------------------------------------------------------------------------
module writeback_fifo
    import writeback_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [ADDR_W-1:0]        head_addr_o,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [$clog2(DEPTH)-1:0] head_ptr_o,
    output logic [ADDR_W-1:0]        tag_o [DEPTH],
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = cnt_width(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly PTR_W bits wide and DEPTH is a power of two, so
    // the +1 wraps modulo DEPTH on its own.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_pop)  head_d = head_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: storage is reset here only because the queue must come up
            // with every slot zeroed; plain data RAMs normally skip this.
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value regardless of statement order.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_push) begin
                addr_q[tail_q] <= addr_i;
                data_q[tail_q] <= data_i;
            end
        end
    end

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign head_ptr_o  = head_q;
    assign count_o     = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) tag_o[i] = addr_q[i];
    end

endmodule

// File: rtl/writeback_queue.sv
// ----------------------------------------------------------------------------
// writeback_queue
// In-order write-back queue feeding the register file and the operand
// forwarding bus, with a RAW hazard flag for results still queued behind head.
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : execute handshake (iValid/oReady/iResult_*), regfile write
//                  port (oWrite_*/iWrite_Ack), forwarding bus (Result_*),
//                  decode sources + oHazard, oCount, sticky oOverflow
// The head entry drives both the write port and the forwarding bus; when the
// queue is empty all address/data outputs read as zero.
// ----------------------------------------------------------------------------
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    writeback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = cnt_width(DEPTH);

    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [PTR_W-1:0]  head_ptr;
    logic [ADDR_W-1:0] tag [DEPTH];
    logic [CW-1:0]     count;
    logic              full, empty;
    logic              push, pop;
    logic              hazard;
    logic              overflow_q, overflow_d;

    // Ready depends on occupancy only; a same-cycle pop does not open a slot.
    assign push = bus.iValid && !full;
    assign pop  = bus.iWrite_Ack && !empty;

    writeback_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (Clock),
        .rst         (Reset),
        .push_i      (push),
        .pop_i       (pop),
        .addr_i      (bus.iResult_Add),
        .data_i      (bus.iResult_Data),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .head_ptr_o  (head_ptr),
        .tag_o       (tag),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Scan entries younger than head (offsets 1..count-1). The head itself is
    // already visible on the forwarding bus, so it never raises a hazard.
    always_comb begin
        hazard = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if ((CW'(k) < count) &&
                ((tag[head_ptr + PTR_W'(k)] == bus.Source_Add1) ||
                 (tag[head_ptr + PTR_W'(k)] == bus.Source_Add2)))
                hazard = 1'b1;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (bus.iValid && full) overflow_d = 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign bus.oReady        = !full;
    assign bus.oWrite_Enable = !empty;
    assign bus.Result_Valid  = !empty;
    // Slots keep stale contents after a pop, so mask them when nothing is live.
    assign bus.oWrite_Add    = empty ? '0 : head_addr;
    assign bus.oWrite_Data   = empty ? '0 : head_data;
    assign bus.Result_Add    = empty ? '0 : head_addr;
    assign bus.Result_Data   = empty ? '0 : head_data;
    assign bus.oHazard       = hazard;
    assign bus.oCount        = count;
    assign bus.oOverflow     = overflow_q;

endmodule

// File: tb/tb_writeback_queue.sv
// ----------------------------------------------------------------------------
// tb_writeback_queue
// Table-driven vectors with per-row expected ready/hazard/count, backed by a
// queue scoreboard that predicts head contents, count, overflow and hazard.
// ----------------------------------------------------------------------------
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int DEPTH = DEPTH_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_queue_if #(.ADDR_W(ADDR_W_DEF), .DATA_W(DATA_W_DEF), .DEPTH(DEPTH)) wb ();

    writeback_queue #(.ADDR_W(ADDR_W_DEF), .DATA_W(DATA_W_DEF), .DEPTH(DEPTH)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (wb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    entry_t exp_q [$];
    logic   exp_ovf = 1'b0;

    typedef struct {
        logic       v;
        entry_t     e;
        logic       ack;
        logic [7:0] s1;
        logic [7:0] s2;
        logic       e_rdy;
        logic       e_haz;
        int         e_cnt;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic [7:0] a, input logic [15:0] d,
                           input logic ack, input logic [7:0] s1, input logic [7:0] s2,
                           input logic rdy, input logic haz, input int cnt);
        vec_t r;
        r.v = v; r.e.addr = a; r.e.data = d; r.ack = ack;
        r.s1 = s1; r.s2 = s2; r.e_rdy = rdy; r.e_haz = haz; r.e_cnt = cnt;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [15:0] d,
                         input logic ack, input logic [7:0] s1, input logic [7:0] s2);
        wb.iValid       = v;
        wb.iResult_Add  = a;
        wb.iResult_Data = d;
        wb.iWrite_Ack   = ack;
        wb.Source_Add1  = s1;
        wb.Source_Add2  = s2;
    endtask

    function automatic logic model_hazard(input logic [7:0] s1, input logic [7:0] s2);
        logic h = 1'b0;
        for (int i = 1; i < exp_q.size(); i++)
            if (exp_q[i].addr == s1 || exp_q[i].addr == s2) h = 1'b1;
        return h;
    endfunction

    // Called just after inputs are driven (low clock phase). Compares every
    // output against the scoreboard, updates it for the coming edge, and
    // returns at the following falling edge.
    task automatic step();
        logic do_pop, do_push;
        #1;
        check("ready",    32'(wb.oReady),        32'(exp_q.size() != DEPTH));
        check("count",    32'(wb.oCount),        32'(exp_q.size()));
        check("overflow", 32'(wb.oOverflow),     32'(exp_ovf));
        check("hazard",   32'(wb.oHazard),       32'(model_hazard(wb.Source_Add1, wb.Source_Add2)));
        check("wr_en",    32'(wb.oWrite_Enable), 32'(exp_q.size() != 0));
        check("res_vld",  32'(wb.Result_Valid),  32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("wr_add",   32'(wb.oWrite_Add),  32'(exp_q[0].addr));
            check("wr_data",  32'(wb.oWrite_Data), 32'(exp_q[0].data));
            check("res_add",  32'(wb.Result_Add),  32'(exp_q[0].addr));
            check("res_data", 32'(wb.Result_Data), 32'(exp_q[0].data));
        end else begin
            check("wr_add_empty",   32'(wb.oWrite_Add),  32'h0);
            check("wr_data_empty",  32'(wb.oWrite_Data), 32'h0);
            check("res_add_empty",  32'(wb.Result_Add),  32'h0);
            check("res_data_empty", 32'(wb.Result_Data), 32'h0);
        end
        do_pop  = wb.iWrite_Ack && (exp_q.size() != 0);
        do_push = wb.iValid && (exp_q.size() != DEPTH);
        if (wb.iValid && exp_q.size() == DEPTH) exp_ovf = 1'b1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
            entry_t e;
            e.addr = wb.iResult_Add;
            e.data = wb.iResult_Data;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},    32'(wb.oWrite_Enable), 32'h0);
        check({tag, "_res_vld"},  32'(wb.Result_Valid),  32'h0);
        check({tag, "_wr_add"},   32'(wb.oWrite_Add),    32'h0);
        check({tag, "_wr_data"},  32'(wb.oWrite_Data),   32'h0);
        check({tag, "_res_add"},  32'(wb.Result_Add),    32'h0);
        check({tag, "_res_data"}, 32'(wb.Result_Data),   32'h0);
        check({tag, "_count"},    32'(wb.oCount),        32'h0);
        check({tag, "_ovf"},      32'(wb.oOverflow),     32'h0);
        check({tag, "_hazard"},   32'(wb.oHazard),       32'h0);
        check({tag, "_ready"},    32'(wb.oReady),        32'h1);
    endtask

    initial begin
        // ---- Vector table: {inputs, ready/hazard before edge, count after} ----
        // Queue already holds 0x05/0x1234 from the reset-release edge.
        add_vec(0, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 1, 0, 1);  // hold, no ack
        add_vec(0, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 1, 0, 1);
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 0);  // ack retires it
        add_vec(1, 8'h01, 16'h1001, 0, 8'h00, 8'h00, 1, 0, 1);  // fill 01..04
        add_vec(1, 8'h02, 16'h1002, 0, 8'h00, 8'h00, 1, 0, 2);
        add_vec(1, 8'h03, 16'h1003, 0, 8'h00, 8'h00, 1, 0, 3);
        add_vec(1, 8'h04, 16'h1004, 0, 8'h00, 8'h00, 1, 0, 4);
        add_vec(1, 8'h05, 16'h1005, 0, 8'h00, 8'h00, 0, 0, 4);  // dropped, overflow
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 0, 0, 3);  // retire in order
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 2);
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 1);
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 0);
        add_vec(1, 8'h0A, 16'h200A, 0, 8'h00, 8'h00, 1, 0, 1);  // hazard scenario
        add_vec(1, 8'h0B, 16'h200B, 0, 8'h00, 8'h00, 1, 0, 2);
        add_vec(0, 8'h00, 16'h0000, 0, 8'h0A, 8'h00, 1, 0, 2);  // head match only
        add_vec(0, 8'h00, 16'h0000, 0, 8'h0A, 8'h0B, 1, 1, 2);  // non-head match
        add_vec(0, 8'h00, 16'h0000, 1, 8'h0A, 8'h0B, 1, 1, 1);  // ack head
        add_vec(0, 8'h00, 16'h0000, 0, 8'h00, 8'h0B, 1, 0, 1);  // 0x0B now head
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 0);
        add_vec(1, 8'h10, 16'h3010, 0, 8'h00, 8'h00, 1, 0, 1);  // full + same-cycle ack
        add_vec(1, 8'h11, 16'h3011, 0, 8'h00, 8'h00, 1, 0, 2);
        add_vec(1, 8'h12, 16'h3012, 0, 8'h00, 8'h00, 1, 0, 3);
        add_vec(1, 8'h13, 16'h3013, 0, 8'h00, 8'h00, 1, 0, 4);
        add_vec(1, 8'h14, 16'h3014, 1, 8'h00, 8'h00, 0, 0, 3);  // push rejected, pop done
        add_vec(1, 8'h15, 16'h3015, 0, 8'h00, 8'h00, 1, 0, 4);  // next push accepted
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 0, 0, 3);
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 2);
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 1);
        add_vec(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0, 0);

        // ---- Reset with iValid held high ----
        drive(1, 8'h05, 16'h1234, 0, 8'h00, 8'h00);
        #3 check_all_zero("rst_a");
        @(posedge clk); #1 check_all_zero("rst_b");
        @(negedge clk);
        rst = 1'b0;
        step();  // first edge after release performs the push
        check("first_push_count", 32'(wb.oCount), 32'h1);
        check("first_push_add",   32'(wb.Result_Add), 32'h05);
        check("first_push_data",  32'(wb.Result_Data), 32'h1234);

        // ---- Table ----
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].e.addr, vecs[i].e.data, vecs[i].ack, vecs[i].s1, vecs[i].s2);
            #1;
            check($sformatf("vec%0d_ready", i),  32'(wb.oReady),  32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_hazard", i), 32'(wb.oHazard), 32'(vecs[i].e_haz));
            step();
            check($sformatf("vec%0d_count", i),  32'(wb.oCount),  32'(vecs[i].e_cnt));
        end
        check("ovf_sticky", 32'(wb.oOverflow), 32'h1);

        // ---- Continuous push+ack across pointer wrap ----
        drive(1, 8'h40, 16'h5040, 0, 8'h00, 8'h00);
        step();
        for (int i = 1; i <= 10; i++) begin
            drive(1, 8'(8'h40 + i), 16'(16'h5040 + i), 1, 8'h00, 8'h00);
            step();
            check($sformatf("wrap%0d_count", i), 32'(wb.oCount), 32'h1);
            check($sformatf("wrap%0d_head", i),  32'(wb.Result_Add), 32'(8'h40 + i));
        end
        drive(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00);
        step();
        check("wrap_drained", 32'(wb.oCount), 32'h0);

        // ---- Random traffic with narrow addresses to provoke duplicates ----
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
            step();
        end

        // ---- Asynchronous reset mid-operation ----
        for (int i = 0; i <= DEPTH; i++) begin
            drive(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00);
            step();
        end
        drive(1, 8'h21, 16'h6021, 0, 8'h00, 8'h00); step();
        drive(1, 8'h22, 16'h6022, 0, 8'h00, 8'h00); step();
        drive(1, 8'h23, 16'h6023, 0, 8'h00, 8'h00); step();
        drive(0, 8'h00, 16'h0000, 0, 8'h22, 8'h23);
        #1 check("pre_rst_hazard", 32'(wb.oHazard), 32'h1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 8'h30, 16'h7030, 0, 8'h00, 8'h00); step();
        drive(0, 8'h00, 16'h0000, 1, 8'h00, 8'h00); step();
        drive(0, 8'h00, 16'h0000, 0, 8'h00, 8'h00); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Write-back result queue at the end of the pipeline, on the producer side of the read-after-write forwarding interface. It accepts results from execute over a valid/ready handshake and buffers them in order. It retires the oldest result to the register-file write port and drives that same result onto the forwarding bus (Result_Add/Result_Data) that the operand-forwarding unit compares against source addresses. It also flags a hazard when a decoded source operand matches a queued result that is not yet on the forwarding bus.

## Interface
- DEPTH, 4: queue entries, power of two, at least 2
- ADDR_W, 8: register address width
- DATA_W, 16: data width
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high
- iValid  in  1  execute presents a result
- oReady  out  1  queue can accept this cycle
- iResult_Add  in  ADDR_W  destination register of the incoming result
- iResult_Data  in  DATA_W  incoming result value
- oWrite_Enable  out  1  register-file write request
- iWrite_Ack  in  1  register file accepts the write this cycle
- oWrite_Add  out  ADDR_W  register-file write address
- oWrite_Data  out  DATA_W  register-file write data
- Result_Valid  out  1  forwarding bus holds a live result
- Result_Add  out  ADDR_W  forwarding address (head entry)
- Result_Data  out  DATA_W  forwarding data (head entry)
- Source_Add1  in  ADDR_W  decode source address 1
- Source_Add2  in  ADDR_W  decode source address 2
- oHazard  out  1  a non-head entry matches either source address
- oCount  out  clog2(DEPTH)+1  current occupancy
- oOverflow  out  1  sticky: iValid seen while oReady was low

## Operation
- Circular buffer with a head pointer, a tail pointer, and a count register.
- oReady = (count != DEPTH). It is a function of count only and does not look at a same-cycle pop.
- Push when iValid && oReady: the entry is written at the tail, and the tail and count advance.
- iValid while !oReady is dropped and sets oOverflow. oOverflow is cleared only by Reset.
- Head entry drives both oWrite_Add/oWrite_Data and Result_Add/Result_Data.
- oWrite_Enable = Result_Valid = (count != 0).
- Pop when oWrite_Enable && iWrite_Ack: the head advances and count decrements.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- If the queue is empty, all address and data outputs are forced to 0.
- oHazard is combinational. It is 1 if any occupied entry at offset 1 to count-1 from the head has an address equal to Source_Add1 or Source_Add2. The head entry is excluded because it is already forwarded.
- Duplicate addresses in the queue are legal. They retire in arrival order.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: count 0, head 0, tail 0, all storage 0, oOverflow 0, oReady 1. All other outputs are 0.
- Accept-to-head latency is 1 cycle. A result pushed into an empty queue at edge N appears on the write port and forwarding bus after edge N.
- A head entry stays stable on all outputs until the edge where it is acked. The next entry appears after that edge.
- Throughput is one push and one pop per cycle.
- Full with a same-cycle ack: oReady stays 0 that cycle and rises the cycle after the pop.
- Reset mid-operation discards all queued entries immediately, asynchronously. No write request is issued for discarded entries.
- oHazard and oReady have no registered delay. oHazard reflects the source addresses in the same cycle.

## Structure
- Shared package holds:
  - ADDR_W, DATA_W, and DEPTH defaults.
  - An entry record {address, data}.
  - The width function used for oCount.
- One sub-module, writeback_fifo: storage, pointers, count, and the full/empty flags.
- The top level adds the write handshake, the forwarding-bus mux, the hazard comparators, and the overflow flag.

## Test plan
- Reset with iValid=1 held -> all outputs 0 and oReady=1 during Reset. First push occurs on the first edge after Reset deasserts.
- Push (0x05, 0x1234) with iWrite_Ack=0 -> next cycle oWrite_Enable=1, Result_Add=0x05, Result_Data=0x1234. Values hold until iWrite_Ack=1, then oCount returns to 0.
- Push addresses 0x01, 0x02, 0x03, 0x04 with no ack -> oCount=4 and oReady=0. A fifth push sets oOverflow=1, which stays set until Reset. Acks then retire 0x01 through 0x04 in order.
- Queue holds 0x0A (head) and 0x0B; set Source_Add1=0x0A -> oHazard=0. Set Source_Add2=0x0B -> oHazard=1. After the head is acked, Source_Add2=0x0B -> oHazard=0.
- Full queue with simultaneous iValid and iWrite_Ack -> push is rejected (oOverflow=1) and the pop completes, so oCount=3. The next push is accepted.
- Continuous push and ack for 10 cycles across pointer wrap -> oCount stays 1. The write sequence equals the push sequence with 1-cycle latency.
